// File: rtl/simple_udpsend.sv
// rtl/simple_udpsend.sv - UDP packet generator on the UPL send port: header plus incrementing payload
module simple_udpsend #(
    parameter logic [31:0] MY_IP       = 32'h0a000003,
    parameter logic [15:0] MY_PORT     = 16'h4000,
    parameter int          MAX_WORDS   = 366,
    parameter int          ACK_TIMEOUT = 1024,
    parameter int          IFG_CYCLES  = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dst_ip,
    input  logic [15:0] dst_port,
    input  logic [15:0] num_words,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] seq,
    output logic        UPLout_Request,
    input  logic        UPLout_Ack,
    output logic        UPLout_Enable,
    output logic [31:0] UPLout_Data
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_PAY  = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    localparam logic [15:0] MAX_LEN  = 16'(MAX_WORDS);
    localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'(IFG_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] len_q, len_d;
    logic [31:0] dst_ip_q, dst_ip_d;
    logic [15:0] dst_port_q, dst_port_d;
    logic [15:0] seq_q, seq_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        req_q, req_d;
    logic        en_q, en_d;
    logic [31:0] data_q, data_d;
    logic [15:0] byte_len;

    assign byte_len = 16'(len_q << 2);

    // cnt_q is shared: Ack wait in REQ, header index in HDR, payload index in PAY, idle count in GAP
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        dst_ip_d   = dst_ip_q;
        dst_port_d = dst_port_q;
        seq_d      = seq_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        req_d      = 1'b0;
        en_d       = 1'b0;
        data_d     = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (start && num_words != 16'h0) begin
                    dst_ip_d   = dst_ip;
                    dst_port_d = dst_port;
                    len_d      = (num_words > MAX_LEN) ? MAX_LEN : num_words;
                    cnt_d      = 16'h0;
                    req_d      = 1'b1;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                // a grant on the expiry edge wins over the timeout
                if (UPLout_Ack) begin
                    en_d    = 1'b1;
                    data_d  = MY_IP;
                    cnt_d   = 16'h1;
                    state_d = S_HDR;
                end else if (cnt_q == ACK_LAST) begin
                    timeout_d = 1'b1;
                    cnt_d     = 16'h0;
                    state_d   = S_GAP;
                end else begin
                    req_d = 1'b1;
                    cnt_d = cnt_q + 16'h1;
                end
            end
            S_HDR: begin
                en_d = 1'b1;
                case (cnt_q[1:0])
                    2'd1:    data_d = dst_ip_q;
                    2'd2:    data_d = {MY_PORT, dst_port_q};
                    default: data_d = {byte_len, 16'h0000};
                endcase
                if (cnt_q[1:0] == 2'd3) begin
                    cnt_d   = 16'h0;
                    state_d = S_PAY;
                end else begin
                    cnt_d = cnt_q + 16'h1;
                end
            end
            S_PAY: begin
                if (cnt_q == len_q) begin
                    done_d  = 1'b1;
                    seq_d   = seq_q + 16'h1;
                    cnt_d   = 16'h0;
                    state_d = S_GAP;
                end else begin
                    en_d   = 1'b1;
                    data_d = {seq_q, cnt_q};
                    cnt_d  = cnt_q + 16'h1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 16'h0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'h1;
                end
            end
            default: begin
                cnt_d   = 16'h0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'h0;
            len_q      <= 16'h0;
            dst_ip_q   <= 32'h0;
            dst_port_q <= 16'h0;
            seq_q      <= 16'h0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            req_q      <= 1'b0;
            en_q       <= 1'b0;
            data_q     <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            dst_ip_q   <= dst_ip_d;
            dst_port_q <= dst_port_d;
            seq_q      <= seq_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            req_q      <= req_d;
            en_q       <= en_d;
            data_q     <= data_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign timeout        = timeout_q;
    assign seq            = seq_q;
    assign UPLout_Request = req_q;
    assign UPLout_Enable  = en_q;
    assign UPLout_Data    = data_q;

endmodule

// File: tb/tb_simple_udpsend.sv
// tb/tb_simple_udpsend.sv - bench for simple_udpsend: packet-level model plus directed vectors
module tb_simple_udpsend;

    localparam int ACK_T = 16;
    localparam int IFG   = 12;
    localparam int MAXW  = 366;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dst_ip = 32'h0;
    logic [15:0] dst_port = 16'h0;
    logic [15:0] num_words = 16'h0;
    logic        busy, done, timeout;
    logic [15:0] seq;
    logic        req, ack, en;
    logic [31:0] data;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cap_q[$];
    logic [15:0] mseq = 16'h0;
    bit          ack_on = 1'b1;
    int          ack_delay = 0;

    simple_udpsend #(.ACK_TIMEOUT(ACK_T), .IFG_CYCLES(IFG), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .start(start), .dst_ip(dst_ip), .dst_port(dst_port),
        .num_words(num_words), .busy(busy), .done(done), .timeout(timeout), .seq(seq),
        .UPLout_Request(req), .UPLout_Ack(ack), .UPLout_Enable(en), .UPLout_Data(data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    // packet model: header words then {seq, index} payload, length clamped to MAXW
    task automatic push_packet(input logic [31:0] ip, input logic [15:0] port, input int nw);
        int len;
        len = (nw > MAXW) ? MAXW : nw;
        exp_q.push_back(32'h0a000003);
        exp_q.push_back(ip);
        exp_q.push_back({16'h4000, port});
        exp_q.push_back({16'(len * 4), 16'h0000});
        for (int i = 0; i < len; i++) exp_q.push_back({mseq, 16'(i)});
        mseq = mseq + 16'h1;
    endtask

    // Ack responder: grants after ack_delay extra Request cycles
    initial begin
        int rc;
        rc = 0;
        ack = 1'b0;
        forever begin
            @(negedge clk);
            if (req && ack_on) begin
                rc++;
                ack = (rc > ack_delay);
            end else begin
                rc = 0;
                ack = 1'b0;
            end
        end
    end

    // cycle-by-cycle compare against the model stream
    always @(negedge clk) begin
        if (!reset) begin
            chk("req_en_overlap", {31'h0, req & en}, 32'h0);
            if (en) begin
                cap_q.push_back(data);
                if (exp_q.size() == 0) chk("unexpected_enable", 32'h1, 32'h0);
                else chk("stream_word", data, exp_q.pop_front());
            end else begin
                chk("data_idle_zero", data, 32'h0);
            end
        end
    end

    task automatic do_start(input logic [31:0] ip, input logic [15:0] port, input logic [15:0] nw);
        @(posedge clk);
        #1;
        start = 1'b1; dst_ip = ip; dst_port = port; num_words = nw;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin seen = 1'b1; break; end
        end
        chk("done_seen", {31'h0, seen}, 32'h1);
    endtask

    task automatic wait_idle(input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (busy === 1'b0) begin seen = 1'b1; break; end
        end
        chk("idle_seen", {31'h0, seen}, 32'h1);
    endtask

    initial begin
        int nreq, nto, t_to, t_idle, ndone, t_done, t_req, n;
        bit prev_req, seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_req", {31'h0, req}, 32'h0);
        chk("rst_en", {31'h0, en}, 32'h0);
        chk("rst_data", data, 32'h0);
        chk("rst_seq", {16'h0, seq}, 32'h0);
        chk("rst_done_to", {30'h0, done, timeout}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // basic packet, Ack after a few Request cycles
        ack_delay = 5;
        cap_q.delete();
        push_packet(32'h0a000001, 16'h4000, 3);
        do_start(32'h0a000001, 16'h4000, 16'd3);
        wait_done(100);
        chk("basic_cnt", cap_q.size(), 32'd7);
        if (cap_q.size() == 7) begin
            chk("basic_w0", cap_q[0], 32'h0a000003);
            chk("basic_w1", cap_q[1], 32'h0a000001);
            chk("basic_w2", cap_q[2], 32'h40004000);
            chk("basic_w3", cap_q[3], 32'h000c0000);
            chk("basic_p0", cap_q[4], 32'h00000000);
            chk("basic_p2", cap_q[6], 32'h00000002);
        end
        chk("basic_seq", {16'h0, seq}, {16'h0, mseq});
        chk("basic_seq_lit", {16'h0, seq}, 32'h1);
        chk("basic_drained", exp_q.size(), 32'h0);
        @(negedge clk);
        chk("done_one_cycle", {31'h0, done}, 32'h0);
        wait_idle(40);

        // Ack timeout
        ack_on = 1'b0;
        nreq = 0; nto = 0; t_to = -1; t_idle = -1;
        do_start(32'h0a000002, 16'h1234, 16'd4);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (req) nreq++;
            if (timeout) begin nto++; t_to = c; end
            if (t_to >= 0 && t_idle < 0 && !busy) t_idle = c;
        end
        chk("to_req_cycles", nreq, ACK_T);
        chk("to_pulses", nto, 32'd1);
        chk("to_gap", t_idle - t_to, IFG);
        chk("to_seq", {16'h0, seq}, 32'h1);
        ack_on = 1'b1;
        ack_delay = 0;

        // zero length is ignored
        do_start(32'h0a000002, 16'h1234, 16'd0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (busy || req) seen = 1'b1;
        end
        chk("zero_len_ignored", {31'h0, seen}, 32'h0);

        // clamp to MAXW
        cap_q.delete();
        push_packet(32'hc0a80001, 16'h0050, 1000);
        do_start(32'hc0a80001, 16'h0050, 16'd1000);
        wait_done(500);
        chk("clamp_cnt", cap_q.size(), 32'd370);
        if (cap_q.size() > 3) chk("clamp_w3", cap_q[3], 32'h05b80000);
        chk("clamp_seq", {16'h0, seq}, 32'h2);
        wait_idle(40);

        // start held high: two packets, gap measured between them
        cap_q.delete();
        push_packet(32'h0a000009, 16'h0007, 2);
        push_packet(32'h0a000009, 16'h0007, 2);
        @(posedge clk);
        #1;
        start = 1'b1; dst_ip = 32'h0a000009; dst_port = 16'h0007; num_words = 16'd2;
        ndone = 0; t_done = -1; t_req = -1; prev_req = 1'b0;
        for (int c = 0; c < 200 && ndone < 2; c++) begin
            @(negedge clk);
            if (req && !prev_req && ndone == 1) t_req = c;
            prev_req = req;
            if (done) begin
                ndone++;
                if (ndone == 1) t_done = c;
                if (ndone == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b_packets", ndone, 32'd2);
        chk("b2b_gap", t_req - t_done, IFG + 1);
        chk("b2b_cnt", cap_q.size(), 32'd12);
        if (cap_q.size() > 10) chk("b2b_second_p0", cap_q[10], 32'h00030000);
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (req) n++;
        end
        chk("b2b_no_extra", n, 32'd0);

        // reset in the middle of the payload
        push_packet(32'h0a000005, 16'h0abc, 10);
        do_start(32'h0a000005, 16'h0abc, 16'd10);
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (en && data == 32'h00040002) begin seen = 1'b1; break; end
        end
        chk("mid_word_seen", {31'h0, seen}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_en", {31'h0, en}, 32'h0);
        chk("mid_rst_req", {31'h0, req}, 32'h0);
        chk("mid_rst_seq", {16'h0, seq}, 32'h0);
        chk("mid_rst_busy_done", {30'h0, busy, done}, 32'h0);
        exp_q.delete();
        mseq = 16'h0;
        @(posedge clk);
        #1 reset = 1'b0;
        cap_q.delete();
        push_packet(32'h0a000005, 16'h0abc, 2);
        do_start(32'h0a000005, 16'h0abc, 16'd2);
        wait_done(100);
        chk("post_rst_cnt", cap_q.size(), 32'd6);
        if (cap_q.size() == 6) begin
            chk("post_rst_p0", cap_q[4], 32'h00000000);
            chk("post_rst_p1", cap_q[5], 32'h00000001);
        end
        chk("post_rst_seq", {16'h0, seq}, 32'h1);
        wait_idle(40);
        chk("final_drained", exp_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
